id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//   RV32I decode stage. Splits InstrD into fields, decodes control signals and
//   extends the immediate. Holds the 32x32 register file, written by WB with
//   a same-cycle write-to-read bypass.
//   Produces every *D input the ID/EX pipeline register consumes.
// PARAMETERS
//   XLEN    32  datapath width
//   NREGS   32  architectural registers; x0 is hardwired to zero
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high reset
//   InstrD       in   32  instruction from the IF/ID register
//   RegWriteW    in   1   writeback write enable
//   RdW          in   5   writeback destination register
//   ResultW      in   32  writeback data
//   RegWriteD    out  1   register write enable
//   MemWriteD    out  1   data memory write enable
//   JumpD        out  1   jal
//   BranchD      out  1   beq
//   ALUSrcD      out  1   1 = ALU operand B is ImmExtD
//   ResultSrcD   out  2   00 ALU result, 01 memory, 10 PC+4
//   ALUControlD  out  3   000 add, 001 sub, 010 and, 011 or, 101 slt
//   RD1D         out  32  rs1 read data
//   RD2D         out  32  rs2 read data
//   ImmExtD      out  32  sign-extended immediate
//   RdD          out  5   InstrD[11:7]
//   Rs1D         out  5   InstrD[19:15]
//   Rs2D         out  5   InstrD[24:20]
// BEHAVIOUR
//   - Register file: 31 flops x XLEN. Writes at the posedge when
//     RegWriteW && RdW!=0 && !reset. Writes to x0 are dropped.
//   - Reset: the reset cycle clears all registers to 0 and suppresses any WB
//     write in that cycle. Reset mid-operation loses in-flight WB data
//     (the pipeline is flushed too).
//   - Reads: combinational, 0-cycle latency. Rs==0 always reads 0.
//   - Bypass: if RegWriteW && RdW==Rs1D && RdW!=0 && !reset, RD1D=ResultW.
//     Same rule for RD2D with Rs2D. Bypass is disabled during reset.
//   - Main decoder, opcode -> RegW MemW Jmp Br ALUSrc ResSrc ImmSrc ALUOp:
//     0000011 lw   1 0 0 0 1 01 00 00
//     0100011 sw   0 1 0 0 1 00 01 00
//     0110011 R    1 0 0 0 0 00 -- 10
//     1100011 beq  0 0 0 1 0 00 10 01
//     0010011 I    1 0 0 0 1 00 00 10
//     1101111 jal  1 0 1 0 0 10 11 00
//     Any other opcode (including 0x00000000 from a flushed IF/ID): all
//     controls 0 (bubble).
//   - ALU decoder: ALUOp 00 -> add. ALUOp 01 -> sub.
//   - ALU decoder, ALUOp 10, by funct3:
//     000: sub if op[5]&funct7[5], else add.
//     010: slt. 110: or. 111: and. Any other funct3: add.
//   - ImmSrc 00 (I): {{20{I[31]}},I[31:20]}
//   - ImmSrc 01 (S): {{20{I[31]}},I[31:25],I[11:7]}
//   - ImmSrc 10 (B): {{20{I[31]}},I[7],I[30:25],I[11:8],1'b0}
//   - ImmSrc 11 (J): {{12{I[31]}},I[19:12],I[20],I[30:21],1'b0}
//   - No stall or clear inputs here. Stall and flush are handled by the
//     surrounding pipeline registers.
// CONFIGURATION
//   ID_ILLEGAL_DETECT_EN
//   - Defined: adds output IllegalD (1 bit). It is 1 for an unknown opcode,
//     or an R-type with funct7 not 0000000/0100000. When 1, all controls are
//     forced to 0. A sticky flop IllegalSeen (output, 1 bit) is set on the
//     first IllegalD and cleared only by reset.
//   - Undefined: neither port exists. Unknown opcodes decode to the bubble.
// TESTING
//   - Reset with RegWriteW=1, RdW=5, ResultW=0xDEAD -> next cycle x5 reads 0.
//   - Write x3=0x1234 then read Rs1=3 -> RD1D=0x1234.
//   - RegWriteW=1, RdW=0, ResultW=0xFFFF -> x0 reads 0.
//   - Same-cycle bypass: RegWriteW=1, RdW=7, ResultW=0xAA, InstrD add x1,x7,x7
//     -> RD1D=RD2D=0xAA in that cycle.
//   - Decode: InstrD=0xFFC4A303 (lw x6,-4(x9)) -> RegWriteD=1, ResultSrcD=01,
//     ALUSrcD=1, ImmExtD=0xFFFFFFFC, RdD=6, Rs1D=9.
//   - Decode: InstrD=0xFE420AE3 (beq x4,x4,-12) -> BranchD=1,
//     ALUControlD=001, ImmExtD=0xFFFFFFF4. InstrD=0 -> all controls 0.

Source files
------------

// File: rtl/id_stage.sv
// ============================================================================
// id_stage -- RV32I instruction decode stage
//
// Purpose:
//   Splits the instruction held in the IF/ID register into its fields and
//   decodes the control signals. Extends the immediate to 32 bits. Holds the
//   architectural register file, which the writeback stage writes.
//   A same-cycle write-to-read bypass lets an instruction in decode see the
//   value being written back in that cycle.
//   Every *D output feeds the ID/EX pipeline register.
//
// Parameters:
//   XLEN   datapath width (32)
//   NREGS  number of architectural registers (32); x0 is hardwired to zero
//
// Ports:
//   clk          in   1     rising-edge clock
//   reset        in   1     synchronous, active-high reset
//   InstrD       in   32    instruction from the IF/ID register
//   RegWriteW    in   1     writeback write enable
//   RdW          in   5     writeback destination register
//   ResultW      in   XLEN  writeback data
//   RegWriteD    out  1     register write enable
//   MemWriteD    out  1     data memory write enable
//   JumpD        out  1     jal
//   BranchD      out  1     beq
//   ALUSrcD      out  1     1 = ALU operand B is ImmExtD
//   ResultSrcD   out  2     00 ALU result, 01 memory, 10 PC+4
//   ALUControlD  out  3     000 add, 001 sub, 010 and, 011 or, 101 slt
//   RD1D         out  XLEN  rs1 read data
//   RD2D         out  XLEN  rs2 read data
//   ImmExtD      out  32    sign-extended immediate
//   RdD          out  5     InstrD[11:7]
//   Rs1D         out  5     InstrD[19:15]
//   Rs2D         out  5     InstrD[24:20]
//
// Optional feature (macro ID_ILLEGAL_DETECT_EN):
//   When the macro is defined, the module adds two outputs.
//   IllegalD    out  1  unknown opcode, or an R-type with a bad funct7.
//                       When it is set, all controls are forced to 0.
//   IllegalSeen out  1  sticky flag. It is set by the first IllegalD and
//                       cleared only by reset.
//   When the macro is not defined, unknown opcodes decode to a bubble.
// ============================================================================
module id_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     InstrD,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteD,
    output logic            MemWriteD,
    output logic            JumpD,
    output logic            BranchD,
    output logic            ALUSrcD,
    output logic [1:0]      ResultSrcD,
    output logic [2:0]      ALUControlD,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [31:0]     ImmExtD,
    output logic [4:0]      RdD,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D
`ifdef ID_ILLEGAL_DETECT_EN
    ,
    output logic            IllegalD,
    output logic            IllegalSeen
`endif
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [6:0] opcode;
    logic [2:0] funct3;

    logic       dec_reg_write;
    logic       dec_mem_write;
    logic       dec_jump;
    logic       dec_branch;
    logic       dec_alu_src;
    logic [1:0] dec_result_src;
    logic [1:0] imm_src;
    logic [1:0] alu_op;
    logic [2:0] dec_alu_control;

    // x1..x31 only; x0 has no storage and is produced as a constant on read
    logic [XLEN-1:0] regs [1:NREGS-1];

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign RdD    = InstrD[11:7];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    // Register file write port. Reset wins over a writeback in the same cycle,
    // so an in-flight WB result is lost together with the rest of the pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWriteW && (RdW != 5'd0)) begin
            regs[RdW] <= ResultW;
        end
    end

    // Read ports are combinational. A matching writeback in the same cycle is
    // forwarded so that decode does not see a stale value. The bypass is
    // suppressed during reset because that write never lands.
    always_comb begin
        RD1D = '0;
        if (Rs1D != 5'd0) begin
            if (RegWriteW && !reset && (RdW == Rs1D)) begin
                RD1D = ResultW;
            end else begin
                RD1D = regs[Rs1D];
            end
        end
    end

    always_comb begin
        RD2D = '0;
        if (Rs2D != 5'd0) begin
            if (RegWriteW && !reset && (RdW == Rs2D)) begin
                RD2D = ResultW;
            end else begin
                RD2D = regs[Rs2D];
            end
        end
    end

    // Main decoder. Unknown opcodes fall through to the all-zero bubble.
    // A flushed IF/ID register holds 0x00000000, which takes the same path.
    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_jump       = 1'b0;
        dec_branch     = 1'b0;
        dec_alu_src    = 1'b0;
        dec_result_src = 2'b00;
        imm_src        = 2'b00;
        alu_op         = 2'b00;
        case (opcode)
            OP_LW: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = 2'b01;
                imm_src        = 2'b00;
                alu_op         = 2'b00;
            end
            OP_SW: begin
                dec_mem_write  = 1'b1;
                dec_alu_src    = 1'b1;
                imm_src        = 2'b01;
                alu_op         = 2'b00;
            end
            OP_R: begin
                dec_reg_write  = 1'b1;
                alu_op         = 2'b10;
            end
            OP_BEQ: begin
                dec_branch     = 1'b1;
                imm_src        = 2'b10;
                alu_op         = 2'b01;
            end
            OP_I: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                imm_src        = 2'b00;
                alu_op         = 2'b10;
            end
            OP_JAL: begin
                dec_reg_write  = 1'b1;
                dec_jump       = 1'b1;
                dec_result_src = 2'b10;
                imm_src        = 2'b11;
                alu_op         = 2'b00;
            end
            default: begin
                dec_reg_write  = 1'b0;
            end
        endcase
    end

    // ALU decoder. Subtract is chosen for funct3=000 only when the instruction
    // is R-type (opcode bit 5) and funct7 bit 5 is set. This keeps an addi
    // with immediate bit 10 set from being treated as a subtract.
    always_comb begin
        dec_alu_control = ALU_ADD;
        case (alu_op)
            2'b01: dec_alu_control = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  dec_alu_control = (opcode[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  dec_alu_control = ALU_SLT;
                    3'b110:  dec_alu_control = ALU_OR;
                    3'b111:  dec_alu_control = ALU_AND;
                    default: dec_alu_control = ALU_ADD;
                endcase
            end
            default: dec_alu_control = ALU_ADD;
        endcase
    end

    // Immediate extension. Each format reassembles its scattered fields with
    // the sign taken from InstrD[31]. B and J offsets are halfword aligned.
    always_comb begin
        ImmExtD = '0;
        case (imm_src)
            2'b00: ImmExtD = {{20{InstrD[31]}}, InstrD[31:20]};
            2'b01: ImmExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            2'b10: ImmExtD = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            2'b11: ImmExtD = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: ImmExtD = '0;
        endcase
    end

`ifdef ID_ILLEGAL_DETECT_EN
    logic illegal_d;
    logic illegal_seen;

    // Illegal instruction detection: an opcode outside the supported set, or
    // an R-type whose funct7 is neither the base nor the alternate encoding.
    always_comb begin
        illegal_d = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_I, OP_JAL: illegal_d = 1'b0;
            OP_R:    illegal_d = (InstrD[31:25] != 7'b0000000) && (InstrD[31:25] != 7'b0100000);
            default: illegal_d = 1'b1;
        endcase
    end

    // Sticky record of any illegal instruction, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_seen <= 1'b0;
        end else if (illegal_d) begin
            illegal_seen <= 1'b1;
        end
    end

    assign IllegalD    = illegal_d;
    assign IllegalSeen = illegal_seen;

    // An illegal instruction becomes a bubble so it cannot change any state
    always_comb begin
        RegWriteD   = dec_reg_write   && !illegal_d;
        MemWriteD   = dec_mem_write   && !illegal_d;
        JumpD       = dec_jump        && !illegal_d;
        BranchD     = dec_branch      && !illegal_d;
        ALUSrcD     = dec_alu_src     && !illegal_d;
        ResultSrcD  = illegal_d ? 2'b00 : dec_result_src;
        ALUControlD = illegal_d ? 3'b000 : dec_alu_control;
    end
`else
    // Decoded controls go straight to the pipeline register
    always_comb begin
        RegWriteD   = dec_reg_write;
        MemWriteD   = dec_mem_write;
        JumpD       = dec_jump;
        BranchD     = dec_branch;
        ALUSrcD     = dec_alu_src;
        ResultSrcD  = dec_result_src;
        ALUControlD = dec_alu_control;
    end
`endif

endmodule

// File: tb/tb_id_stage.sv
// ============================================================================
// tb_id_stage -- directed self-checking testbench for id_stage
//
// Purpose:
//   Drives hand-built instructions and writeback traffic into id_stage and
//   compares the outputs against hand-computed values. The checks cover the
//   reset state, register file writes, the x0 rule, the same-cycle bypass,
//   the bypass during reset, each decoder row, ALU decoding and every
//   immediate format.
//
// Ports: none (top-level bench)
// ============================================================================
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic [31:0] InstrD;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        RegWriteD;
    logic        MemWriteD;
    logic        JumpD;
    logic        BranchD;
    logic        ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ImmExtD;
    logic [4:0]  RdD;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
`ifdef ID_ILLEGAL_DETECT_EN
    logic        IllegalD;
    logic        IllegalSeen;
`endif

    int compareCount = 0;
    int failCount    = 0;

    id_stage dut (
        .clk         (clk),
        .reset       (reset),
        .InstrD      (InstrD),
        .RegWriteW   (RegWriteW),
        .RdW         (RdW),
        .ResultW     (ResultW),
        .RegWriteD   (RegWriteD),
        .MemWriteD   (MemWriteD),
        .JumpD       (JumpD),
        .BranchD     (BranchD),
        .ALUSrcD     (ALUSrcD),
        .ResultSrcD  (ResultSrcD),
        .ALUControlD (ALUControlD),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .ImmExtD     (ImmExtD),
        .RdD         (RdD),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D)
`ifdef ID_ILLEGAL_DETECT_EN
        ,
        .IllegalD    (IllegalD),
        .IllegalSeen (IllegalSeen)
`endif
    );

    // 10 time-unit clock with rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction encoders built from the architectural field layouts
    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] stype(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] jtype(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // Drive one set of inputs and let the combinational outputs settle
    task automatic applyStimulus(input logic rst, input logic [31:0] instr,
                                 input logic we, input logic [4:0] rd,
                                 input logic [31:0] result);
        reset     = rst;
        InstrD    = instr;
        RegWriteW = we;
        RdW       = rd;
        ResultW   = result;
        #1;
    endtask

    // One comparison point: count it, and report and count any failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge so sampling stays clear of it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] starting id_stage directed test");

        // Reset while WB tries to write x5; the write must be dropped
        applyStimulus(1'b1, rtype(7'h00, 5'd5, 5'd5, 3'b000, 5'd1), 1'b1, 5'd5, 32'h0000DEAD);
        tick();
        applyStimulus(1'b0, rtype(7'h00, 5'd5, 5'd5, 3'b000, 5'd1), 1'b0, 5'd0, 32'h0);
        checkOutput("reset_x5_rd1", RD1D, 32'h0);
        checkOutput("reset_x5_rd2", RD2D, 32'h0);

        // Write x3 = 0x1234, then read it through rs1
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd3, 32'h00001234);
        tick();
        applyStimulus(1'b0, rtype(7'h00, 5'd0, 5'd3, 3'b000, 5'd2), 1'b0, 5'd0, 32'h0);
        checkOutput("x3_read_rd1", RD1D, 32'h00001234);
        checkOutput("x0_read_rd2", RD2D, 32'h0);

        // A write to x0 is neither bypassed nor stored
        applyStimulus(1'b0, rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd1), 1'b1, 5'd0, 32'h0000FFFF);
        checkOutput("x0_no_bypass", RD1D, 32'h0);
        tick();
        applyStimulus(1'b0, rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd1), 1'b0, 5'd0, 32'h0);
        checkOutput("x0_after_write", RD1D, 32'h0);

        // Same-cycle bypass: add x1,x7,x7 while WB writes x7 = 0xAA
        applyStimulus(1'b0, rtype(7'h00, 5'd7, 5'd7, 3'b000, 5'd1), 1'b1, 5'd7, 32'h000000AA);
        checkOutput("bypass_rd1", RD1D, 32'h000000AA);
        checkOutput("bypass_rd2", RD2D, 32'h000000AA);
        checkOutput("add_rs2", {27'b0, Rs2D}, 32'd7);
        checkOutput("add_rd", {27'b0, RdD}, 32'd1);
        tick();
        applyStimulus(1'b0, rtype(7'h00, 5'd7, 5'd7, 3'b000, 5'd1), 1'b0, 5'd0, 32'h0);
        checkOutput("x7_stored", RD1D, 32'h000000AA);

        // The bypass is disabled during reset, and reset then clears x3 and x7
        applyStimulus(1'b1, rtype(7'h00, 5'd3, 5'd7, 3'b000, 5'd1), 1'b1, 5'd7, 32'h00000055);
        checkOutput("reset_no_bypass", RD1D, 32'h000000AA);
        checkOutput("reset_rd2_x3", RD2D, 32'h00001234);
        tick();
        applyStimulus(1'b0, rtype(7'h00, 5'd3, 5'd7, 3'b000, 5'd1), 1'b0, 5'd0, 32'h0);
        checkOutput("reset_clears_x7", RD1D, 32'h0);
        checkOutput("reset_clears_x3", RD2D, 32'h0);

        // lw x6,-4(x9)
        applyStimulus(1'b0, 32'hFFC4A303, 1'b0, 5'd0, 32'h0);
        checkOutput("lw_regwrite", {31'b0, RegWriteD}, 32'd1);
        checkOutput("lw_memwrite", {31'b0, MemWriteD}, 32'd0);
        checkOutput("lw_resultsrc", {30'b0, ResultSrcD}, 32'd1);
        checkOutput("lw_alusrc", {31'b0, ALUSrcD}, 32'd1);
        checkOutput("lw_aluctl", {29'b0, ALUControlD}, 32'd0);
        checkOutput("lw_imm", ImmExtD, 32'hFFFFFFFC);
        checkOutput("lw_rd", {27'b0, RdD}, 32'd6);
        checkOutput("lw_rs1", {27'b0, Rs1D}, 32'd9);

        // beq x4,x4,-12
        applyStimulus(1'b0, 32'hFE420AE3, 1'b0, 5'd0, 32'h0);
        checkOutput("beq_branch", {31'b0, BranchD}, 32'd1);
        checkOutput("beq_regwrite", {31'b0, RegWriteD}, 32'd0);
        checkOutput("beq_alusrc", {31'b0, ALUSrcD}, 32'd0);
        checkOutput("beq_aluctl", {29'b0, ALUControlD}, 32'd1);
        checkOutput("beq_imm", ImmExtD, 32'hFFFFFFF4);

        // An all-zero instruction decodes to a bubble
        applyStimulus(1'b0, 32'h00000000, 1'b0, 5'd0, 32'h0);
        checkOutput("bubble_ctrl",
                    {22'b0, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD},
                    32'd0);

        // sw x5,-20(x2)
        applyStimulus(1'b0, stype(12'hFEC, 5'd5, 5'd2), 1'b0, 5'd0, 32'h0);
        checkOutput("sw_ctrl",
                    {22'b0, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD},
                    {22'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000});
        checkOutput("sw_imm", ImmExtD, 32'hFFFFFFEC);

        // jal x1 with positive and negative offsets
        applyStimulus(1'b0, jtype(21'h000800, 5'd1), 1'b0, 5'd0, 32'h0);
        checkOutput("jal_ctrl",
                    {22'b0, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD},
                    {22'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b000});
        checkOutput("jal_imm_pos", ImmExtD, 32'h00000800);
        applyStimulus(1'b0, jtype(21'h1F2346, 5'd1), 1'b0, 5'd0, 32'h0);
        checkOutput("jal_imm_neg", ImmExtD, 32'hFFFF2346);

        // addi x1,x2,-1024: bit 30 is set, but the op is still add
        applyStimulus(1'b0, itype(12'hC00, 5'd2, 3'b000, 5'd1), 1'b0, 5'd0, 32'h0);
        checkOutput("addi_ctrl",
                    {22'b0, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD},
                    {22'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000});
        checkOutput("addi_imm", ImmExtD, 32'hFFFFFC00);

        // R-type ALU decoding by funct3 and funct7
        applyStimulus(1'b0, rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 5'd0, 32'h0);
        checkOutput("r_sub", {29'b0, ALUControlD}, 32'd1);
        checkOutput("r_sub_alusrc", {31'b0, ALUSrcD}, 32'd0);
        applyStimulus(1'b0, rtype(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 1'b0, 5'd0, 32'h0);
        checkOutput("r_slt", {29'b0, ALUControlD}, 32'd5);
        applyStimulus(1'b0, rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd3), 1'b0, 5'd0, 32'h0);
        checkOutput("r_or", {29'b0, ALUControlD}, 32'd3);
        applyStimulus(1'b0, rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 1'b0, 5'd0, 32'h0);
        checkOutput("r_and", {29'b0, ALUControlD}, 32'd2);
        applyStimulus(1'b0, rtype(7'h00, 5'd2, 5'd1, 3'b100, 5'd3), 1'b0, 5'd0, 32'h0);
        checkOutput("r_other_add", {29'b0, ALUControlD}, 32'd0);
        checkOutput("r_regwrite", {31'b0, RegWriteD}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
